// File: rtl/dac_interp_upsampler.sv
// dac_interp_upsampler: takes one signed sample per frame of N = 2**OSR_LOG2
// clocks and emits one oversampled value per clock for the FIR/sigma-delta
// chain. The frame start (X0) and end (X1) values come from a one-entry
// input buffer.
// Build option: define DAC_INTERP_LINEAR_EN for linear interpolation between
// X0 and X1. Leave it undefined for a zero-order hold (dac_o = X0).
module dac_interp_upsampler #(
    parameter int BW       = 16,
    parameter int OSR_LOG2 = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [BW-1:0] smp_i,
    input  logic                 smp_valid_i,
    output logic                 smp_ready_o,
    output logic signed [BW-1:0] dac_o,
    output logic                 run_o,
    output logic                 underrun_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic signed [BW-1:0]  x0_q;
    logic signed [BW-1:0]  x1_q;
    logic signed [BW-1:0]  nxt_q;
    logic                  nxt_full_q;
    logic [OSR_LOG2-1:0]   k_q;
    logic                  underrun_q;

    logic                  accept;
    logic                  boundary;
    logic                  load_frame;
    logic                  consume;

    // The ready signal is a pure decode of the buffer flag, so valid never
    // reaches ready combinationally.
    assign smp_ready_o = ~nxt_full_q;
    assign accept      = smp_valid_i & ~nxt_full_q;
    assign boundary    = (state_q == RUN) && (k_q == {OSR_LOG2{1'b1}});
    assign run_o       = (state_q == RUN);
    assign underrun_o  = underrun_q;

    // Next-state logic. Both the first load from IDLE and each RUN boundary
    // start a new frame. The buffer is consumed only if it was already full
    // before the boundary cycle.
    always_comb begin
        state_d    = state_q;
        load_frame = 1'b0;
        consume    = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt_full_q) begin
                    load_frame = 1'b1;
                    consume    = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    load_frame = 1'b1;
                    consume    = nxt_full_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and sample registers: the FSM, the input buffer, the frame
    // endpoints, the phase counter and the underrun flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            nxt_q      <= '0;
            nxt_full_q <= 1'b0;
            k_q        <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            underrun_q <= boundary & ~nxt_full_q;
            if (accept) begin
                nxt_q      <= smp_i;
                nxt_full_q <= 1'b1;
            end else if (consume) begin
                nxt_full_q <= 1'b0;
            end
            if (load_frame) begin
                x0_q <= x1_q;
                if (consume) begin
                    x1_q <= nxt_q;
                end
            end
            if (state_q == RUN) begin
                k_q <= k_q + 1'b1;
            end else begin
                k_q <= '0;
            end
        end
    end

`ifdef DAC_INTERP_LINEAR_EN
    localparam int ACC_W = BW + 1 + OSR_LOG2;

    logic signed [BW:0]      diff;
    logic signed [ACC_W-1:0] acc_q;
    logic                    unused_acc_msb;

    assign diff = {x1_q[BW-1], x1_q} - {x0_q[BW-1], x0_q};

    // The accumulator holds X0*N + k*(X1-X0). Because this value stays between
    // X0*N and X1*N, the output slice below cannot overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (load_frame) begin
            acc_q <= {x1_q[BW-1], x1_q, {OSR_LOG2{1'b0}}};
        end else if (state_q == RUN) begin
            acc_q <= acc_q + {{OSR_LOG2{diff[BW]}}, diff};
        end
    end

    // Taking bits above OSR_LOG2 is an arithmetic shift right. The top bit is
    // only headroom for the intermediate sums.
    assign dac_o          = acc_q[OSR_LOG2 +: BW];
    assign unused_acc_msb = acc_q[ACC_W-1];
`else
    // Zero-order hold: repeat the frame start value for every phase.
    assign dac_o = x0_q;
`endif

endmodule
